// File: rtl/mlp_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mlp_adc_sequencer
// Steps a shared ADC across the sensor channels, builds the MLP input vector,
// waits for the classifier to settle and hands the class index out via
// valid/ready.
// Rev    : 1.0
// ============================================================================
module mlp_adc_sequencer #(
    parameter int N_CH         = 6,
    parameter int ADC_W        = 4,
    parameter int CLS_W        = 2,
    parameter int SETTLE_CYC   = 2,
    parameter int CONV_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic [2:0]              adc_sel,
    output logic                    adc_conv,
    input  logic                    adc_done,
    input  logic [ADC_W-1:0]        adc_data,
    output logic [N_CH*ADC_W-1:0]   mlp_inp,
    input  logic [CLS_W-1:0]        mlp_out,
    output logic                    class_valid,
    output logic [CLS_W-1:0]        class_data,
    input  logic                    class_ready,
    output logic                    err_timeout
);

    // One timer serves both the conversion watchdog and the settle delay.
    localparam int              c_tmr_max     = (CONV_TIMEOUT > SETTLE_CYC) ? CONV_TIMEOUT : SETTLE_CYC;
    localparam int              c_tmr_w       = $clog2(c_tmr_max + 1);
    localparam logic [2:0]      c_last_ch     = 3'(N_CH - 1);
    localparam logic [c_tmr_w-1:0] c_tmo_last = c_tmr_w'(CONV_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_stl_last = c_tmr_w'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               r_state;
    logic [2:0]           r_ch;
    logic [c_tmr_w-1:0]   r_tmr;
    logic                 r_busy;

    assign busy     = r_busy;
    assign adc_sel  = r_ch;
    assign adc_conv = (r_state == S_CONV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ch        <= 3'd0;
            r_tmr       <= '0;
            r_busy      <= 1'b0;
            mlp_inp     <= '0;
            class_valid <= 1'b0;
            class_data  <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch        <= 3'd0;
                        err_timeout <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_tmr   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the final watchdog cycle still wins.
                    if (adc_done) begin
                        for (int c = 0; c < N_CH; c++) begin
                            if (r_ch == 3'(c)) begin
                                mlp_inp[c*ADC_W +: ADC_W] <= adc_data;
                            end
                        end
                        if (r_ch == c_last_ch) begin
                            r_tmr   <= '0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_ch    <= r_ch + 3'd1;
                            r_state <= S_CONV;
                        end
                    end else if (r_tmr == c_tmo_last) begin
                        err_timeout <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == c_stl_last) begin
                        class_data  <= mlp_out;
                        class_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (class_ready) begin
                        class_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    class_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_adc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mlp_adc_sequencer
// Randomised ADC/consumer stimulus checked against a cycle-count and
// per-channel-slice reference model.
// Rev    : 1.0
// ============================================================================
module tb_mlp_adc_sequencer;

    localparam int N_CH         = 6;
    localparam int ADC_W        = 4;
    localparam int CLS_W        = 2;
    localparam int SETTLE_CYC   = 2;
    localparam int CONV_TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  busy;
    logic [2:0]            adc_sel;
    logic                  adc_conv;
    logic                  adc_done;
    logic [ADC_W-1:0]      adc_data;
    logic [N_CH*ADC_W-1:0] mlp_inp;
    logic [CLS_W-1:0]      mlp_out;
    logic                  class_valid;
    logic [CLS_W-1:0]      class_data;
    logic                  class_ready;
    logic                  err_timeout;

    int checks   = 0;
    int failures = 0;

    logic [ADC_W-1:0] ref_slice [N_CH];
    int               dly [N_CH];
    logic [ADC_W-1:0] dat [N_CH];

    always #5 clk = ~clk;

    mlp_adc_sequencer #(
        .N_CH(N_CH), .ADC_W(ADC_W), .CLS_W(CLS_W),
        .SETTLE_CYC(SETTLE_CYC), .CONV_TIMEOUT(CONV_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .adc_sel(adc_sel), .adc_conv(adc_conv), .adc_done(adc_done),
        .adc_data(adc_data), .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .class_valid(class_valid), .class_data(class_data),
        .class_ready(class_ready), .err_timeout(err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N_CH*ADC_W-1:0] pack();
        logic [N_CH*ADC_W-1:0] v;
        v = '0;
        for (int c = 0; c < N_CH; c++) v[c*ADC_W +: ADC_W] = ref_slice[c];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_conv"},  32'(adc_conv), 32'd0);
        check({tag, "_sel"},   32'(adc_sel), 32'd0);
        check({tag, "_valid"}, 32'(class_valid), 32'd0);
        check({tag, "_cls"},   32'(class_data), 32'd0);
        check({tag, "_err"},   32'(err_timeout), 32'd0);
        check({tag, "_inp"},   32'(mlp_inp), 32'd0);
    endtask

    // One classification request; caller must be at a sample point in IDLE.
    task automatic run(input int ready_dly, input bit spurious, input int abort_ch);
        int n, conv_cnt, cur, wait_left, settle_left, t_exp, t_tmo, t_valid, tmo_ch;
        bit pending, seen_valid, done_run;
        logic [CLS_W-1:0] last_mlp, held;
        tmo_ch = -1; t_exp = 1; t_tmo = 0; t_valid = 0; held = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (tmo_ch < 0) begin
                if (dly[c] >= CONV_TIMEOUT) begin
                    tmo_ch = c;
                    t_tmo  = t_exp + CONV_TIMEOUT + 1;
                end else begin
                    t_exp += 2 + dly[c];
                end
            end
        end
        if (spurious) begin
            adc_done = 1'b1;
            adc_data = ADC_W'($urandom_range(0, 15));
            tick();
            adc_done = 1'b0;
            check("idle_spur_inp", 32'(mlp_inp), 32'(pack()));
        end
        last_mlp = CLS_W'($urandom_range(0, 3));
        mlp_out  = last_mlp;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 1; conv_cnt = 0; cur = 0; wait_left = 0; settle_left = 0;
        pending = 0; seen_valid = 0; done_run = 0;
        while (!done_run && n < 600) begin
            adc_done = 1'b0;
            if (err_timeout) begin
                check("tmo_cycle", 32'(n), 32'(t_tmo));
                check("tmo_busy", 32'(busy), 32'd0);
                check("tmo_inp", 32'(mlp_inp), 32'(pack()));
                check("tmo_convs", 32'(conv_cnt), 32'(tmo_ch + 1));
                done_run = 1;
            end else begin
                if (class_valid && !seen_valid) begin
                    seen_valid = 1;
                    t_valid    = n;
                    held       = last_mlp;
                    check("valid_cycle", 32'(n), 32'(t_exp + SETTLE_CYC));
                    check("class_data", 32'(class_data), 32'(last_mlp));
                    check("final_inp", 32'(mlp_inp), 32'(pack()));
                    check("conv_count", 32'(conv_cnt), 32'(N_CH));
                    check("no_err", 32'(err_timeout), 32'd0);
                end
                if (seen_valid) begin
                    if (class_valid) begin
                        check("hold_data", 32'(class_data), 32'(held));
                        check("hold_busy", 32'(busy), 32'd1);
                        check("hold_noconv", 32'(adc_conv), 32'd0);
                        class_ready = (n >= t_valid + ready_dly);
                        start = (ready_dly > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    end else begin
                        check("valid_drop", 32'(n), 32'(t_valid + ready_dly + 1));
                        check("idle_busy", 32'(busy), 32'd0);
                        check("idle_noconv", 32'(adc_conv), 32'd0);
                        check("cls_retain", 32'(class_data), 32'(held));
                        class_ready = 1'b0;
                        start = 1'b0;
                        done_run = 1;
                    end
                end else if (adc_conv) begin
                    check("conv_sel", 32'(adc_sel), 32'(conv_cnt));
                    check("conv_busy", 32'(busy), 32'd1);
                    if (conv_cnt == 0) check("err_clr", 32'(err_timeout), 32'd0);
                    cur = conv_cnt;
                    conv_cnt++;
                    pending = 1;
                    wait_left = dly[cur];
                end else if (pending) begin
                    check("wait_sel", 32'(adc_sel), 32'(cur));
                    if (abort_ch == cur) begin
                        #2 rst_n = 1'b0;
                        #1;
                        check_reset_vals("abort");
                        for (int c = 0; c < N_CH; c++) ref_slice[c] = '0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        tick();
                        check_reset_vals("post_abort");
                        done_run = 1;
                    end else if (wait_left == 0) begin
                        adc_done = 1'b1;
                        adc_data = dat[cur];
                        ref_slice[cur] = dat[cur];
                        pending = 0;
                        if (cur == N_CH - 1) settle_left = SETTLE_CYC;
                    end else begin
                        wait_left--;
                    end
                end else if (settle_left > 0) begin
                    check("settle_inp", 32'(mlp_inp), 32'(pack()));
                    if (spurious) begin
                        adc_done = 1'b1;
                        adc_data = ADC_W'($urandom_range(0, 15));
                    end
                    settle_left--;
                end
                if (!seen_valid) begin
                    class_ready = 1'($urandom_range(0, 1));
                    last_mlp = CLS_W'($urandom_range(0, 3));
                    mlp_out  = last_mlp;
                end
            end
            if (!done_run) begin
                tick();
                n++;
            end
        end
        check("run_budget", 32'(done_run), 32'd1);
        adc_done = 1'b0; start = 1'b0; class_ready = 1'b0;
    endtask

    task automatic rand_data();
        for (int c = 0; c < N_CH; c++) dat[c] = ADC_W'($urandom_range(0, 15));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; adc_done = 1'b0; adc_data = '0;
        mlp_out = '0; class_ready = 1'b0;
        for (int c = 0; c < N_CH; c++) ref_slice[c] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal: one WAIT cycle per channel, data 1..6.
        for (int c = 0; c < N_CH; c++) begin dly[c] = 0; dat[c] = ADC_W'(c + 1); end
        run(0, 0, -1);
        check("nominal_vec", 32'(mlp_inp), 32'h654321);

        // Variable latency including the last legal delay.
        dly[0] = 0; dly[1] = 3; dly[2] = 7; dly[3] = 1; dly[4] = 14; dly[5] = 2;
        rand_data();
        run(0, 0, -1);

        // Timeout on channel 2, then a clean run.
        for (int c = 0; c < N_CH; c++) dly[c] = $urandom_range(0, 3);
        dly[2] = 99;
        rand_data();
        run(0, 0, -1);
        for (int c = 0; c < N_CH; c++) dly[c] = $urandom_range(0, 4);
        rand_data();
        run(0, 0, -1);

        // Backpressure with start pulses during HOLD.
        rand_data();
        run(10, 0, -1);

        // Reset during WAIT of channel 3, then a normal run.
        rand_data();
        run(0, 0, 3);
        rand_data();
        run(1, 0, -1);

        // Spurious adc_done in IDLE and SETTLE.
        rand_data();
        run(0, 1, -1);

        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < N_CH; c++)
                dly[c] = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 14);
            rand_data();
            run($urandom_range(0, 5), 1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mlp_adc_sequencer.md
Name: mlp_adc_sequencer

Overview:
- Front-end sequencer for the on-sensor printed MLP classifier.
- On each start request it steps a shared 4-bit ADC across the 6 sensor channels one at a time and packs the results into the 24-bit classifier input vector.
- It then waits a fixed settle time for the combinational MLP and captures the 2-bit class index.
- The class index is presented to the consumer through a valid/ready handshake.

Parameters:
N_CH, 6, number of sensor channels (features).
ADC_W, 4, ADC result width per channel.
CLS_W, 2, class index width.
SETTLE_CYC, 2, cycles the MLP input is held stable before the class is sampled (legal range ≥1).
CONV_TIMEOUT, 15, maximum WAIT_ADC cycles per channel before aborting (legal range ≥1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one classification; honoured only in IDLE
busy  out  1  high in every state except IDLE
adc_sel  out  3  ADC channel select (0..N_CH-1)
adc_conv  out  1  one-cycle conversion strobe
adc_done  in  1  conversion complete; adc_data valid in the same cycle
adc_data  in  ADC_W  ADC result
mlp_inp  out  N_CH*ADC_W  classifier input vector; channel c occupies bits [ADC_W*c+ADC_W-1 : ADC_W*c]
mlp_out  in  CLS_W  classifier argmax result (combinational from mlp_inp)
class_valid  out  1  class_data valid
class_data  out  CLS_W  captured class index
class_ready  in  1  consumer accepts class_data
err_timeout  out  1  sticky flag: ADC conversion timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, adc_conv, class_valid and err_timeout = 0; adc_sel=0; mlp_inp=0; class_data=0; channel and timer counters = 0.
- All outputs are registered. adc_conv is decoded as "state==CONV" from the state register.
- **IDLE**
  - start=1: ch←0, err_timeout←0, next state CONV.
  - start is ignored in every other state, including HOLD.
- **CONV** (1 cycle)
  - adc_conv=1, adc_sel=ch, next state WAIT_ADC, timer←0.
- **WAIT_ADC**
  - adc_sel stays equal to ch.
  - adc_done=1: at that edge, mlp_inp slice ch←adc_data.
    - If ch==N_CH-1: next state SETTLE, timer←0.
    - Otherwise: ch←ch+1, next state CONV.
  - adc_done=0: timer increments.
    - If this was the CONV_TIMEOUT-th WAIT_ADC cycle: next state IDLE, err_timeout←1.
  - adc_done in the CONV_TIMEOUT-th cycle is accepted; acceptance takes priority over timeout.
  - adc_done seen in any state other than WAIT_ADC is ignored.
- **SETTLE**
  - Lasts exactly SETTLE_CYC cycles; mlp_inp is unchanged throughout.
  - At the end of the last cycle: class_data←mlp_out, class_valid←1, next state HOLD.
- **HOLD**
  - class_valid=1 and class_data are stable until class_ready=1.
  - On that edge: class_valid←0, next state IDLE.
  - class_ready while class_valid=0 has no effect.
- mlp_inp retains the last written values between runs and after a timeout abort. Channels not reached in an aborted run keep their previous values.
- class_data retains its last value after the handshake completes.
- Latency: start accepted at edge 0 with adc_done asserted on the first WAIT_ADC cycle of every channel gives
  - 2 cycles per channel;
  - class_valid high in cycle 1 + 2·N_CH + SETTLE_CYC = 15 for the defaults.
- Channel counter never wraps: ch ends at N_CH-1 and is reset to 0 only by a new start.
- Reset asserted mid-run, in any state, returns everything to the reset values immediately. No partial class is ever presented.

Test Plan:
- **Nominal run:** reset → start pulse; ADC model returns done after 1 WAIT cycle with data = 1,2,3,4,5,6 for ch0..5; class_ready held high.
  - mlp_inp=24'h654321; adc_conv pulses six times with adc_sel=0..5; class_valid high at cycle 15 with class_data = mlp_out.
  - Valid drops one cycle later; busy then 0.
- **Variable ADC latency:** done delays of 0,3,7,1,14,2 WAIT cycles.
  - Every sample is captured correctly, including the one at the 14-cycle delay.
  - err_timeout stays 0.
- **Timeout:** ch2 never asserts done.
  - After 15 WAIT cycles: state IDLE, err_timeout=1, busy=0.
  - mlp_inp slices 0,1 updated, slices 2..5 unchanged.
  - Next start clears err_timeout and a full run completes.
- **Backpressure:** class_ready=0 for 10 cycles after class_valid rises.
  - class_valid and class_data stay stable.
  - start pulses during HOLD are ignored (no adc_conv).
  - Handshake completes in the cycle class_ready=1.
- **Reset mid-run:** assert rst_n=0 during WAIT_ADC of ch3.
  - All outputs take their reset values asynchronously, mlp_inp=0.
  - After release, a new start completes a normal run.
- **Spurious inputs:** adc_done pulses in IDLE and SETTLE, and a mlp_out change during SETTLE before its last cycle.
  - No mlp_inp writes occur.
  - class_data equals the mlp_out value present in the final SETTLE cycle.
